// File: rtl/fpga_support_pkg.sv
// Shared encodings and widths for the ntps FPGA support UART blocks.
// Holds the FSM state codes, the data-bit count and the baud counter width.
package fpga_support_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BAUD_CNT_W     = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/support_baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled, tick on the last count.
// Ports: clk, areset (sync, active-high), i_clear (frame start), i_en, o_tick.
module support_baud_tick
  import fpga_support_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic areset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [BAUD_CNT_W-1:0] LAST =
    BAUD_CNT_W'(CLK_DIV - 1);

  logic [BAUD_CNT_W-1:0] r_cnt;
  logic                  w_tick;

  assign w_tick = i_en && (r_cnt == LAST);
  assign o_tick = w_tick;

  always_ff @(posedge clk) begin
    if (areset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/support_uart_tx.sv
// Byte-wide 8N1 serial transmitter, LSB first, idle-high registered txd.
// Ports: clk, areset, tx_valid, tx_data[7:0], tx_ready, tx_done, txd.
// Define SUPPORT_UART_TX_PARITY_EN to insert an even-parity bit before stop.
module support_uart_tx
  import fpga_support_pkg::*;
#(
  parameter int CLK_DIV   = 868,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       txd
);

  localparam logic       STOP_LAST = (STOP_BITS == 2);
  localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_stop_cnt;
  logic       r_txd;
  logic       r_ready;
  logic       r_done;
`ifdef SUPPORT_UART_TX_PARITY_EN
  logic       r_parity;
`endif

  logic w_accept;
  logic w_tick;
  logic w_busy;

  assign w_accept = tx_valid && r_ready;
  assign w_busy   = (r_state != ST_IDLE);

  support_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .areset  (areset),
    .i_clear (w_accept),
    .i_en    (w_busy),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
`ifdef SUPPORT_UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_START;
            r_shift    <= tx_data;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_txd      <= 1'b0;
            r_ready    <= 1'b0;
`ifdef SUPPORT_UART_TX_PARITY_EN
            r_parity   <= ^tx_data;
`endif
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            // counter names the bit currently on the line
            if (r_bit_cnt == BIT_LAST) begin
`ifdef SUPPORT_UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_txd   <= r_parity;
`else
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
`ifdef SUPPORT_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_txd   <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_stop_cnt == STOP_LAST) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign txd      = r_txd;
  assign tx_ready = r_ready;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_support_uart_tx.sv
// Randomised and directed bench for support_uart_tx against a frame-level model.
// Build with SUPPORT_UART_TX_PARITY_EN to cover the parity / two-stop variant.
module tb_support_uart_tx;

  localparam int CLK_DIV = 4;
`ifdef SUPPORT_UART_TX_PARITY_EN
  localparam int STOP_BITS = 2;
  localparam int PBITS     = 1;
  localparam logic [11:0] E_A5 = 12'b110101001010;
  localparam logic [11:0] E_07 = 12'b111000001110;
  localparam logic [11:0] E_FF = 12'b110111111110;
  localparam logic [11:0] E_3C = 12'b110001111000;
  localparam logic [11:0] E_C3 = 12'b110110000110;
  localparam int          E_F  = 48;
`else
  localparam int STOP_BITS = 1;
  localparam int PBITS     = 0;
  localparam logic [11:0] E_A5 = 12'b001101001010;
  localparam logic [11:0] E_07 = 12'b001000001110;
  localparam logic [11:0] E_FF = 12'b001111111110;
  localparam logic [11:0] E_3C = 12'b001001111000;
  localparam logic [11:0] E_C3 = 12'b001110000110;
  localparam int          E_F  = 40;
`endif
  localparam int NB = 1 + 8 + PBITS + STOP_BITS;
  localparam int F  = NB * CLK_DIV;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx_done;
  logic       txd;

  int checks = 0;
  int errors = 0;

  bit         m_busy = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_done = 1'b0;
  int         acc_cnt = 0;
  int         cyc = 0;
  logic       cap [0:127];
  int         ready_low = 0;
  int         done_cnt = 0;
  int         fall_cyc [$];
  logic       prev_ready = 1'b1;
  logic       exp_txd;

  always #5 clk = ~clk;

  support_uart_tx #(
    .CLK_DIV   (CLK_DIV),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .txd      (txd)
  );

  function automatic logic frame_bit(
    input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PBITS == 1 && i == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // frame-level model: line position k (1..F) since accept maps to bit (k-1)/CLK_DIV
  always @(posedge clk) begin
    cyc++;
    if (areset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (!m_busy && tx_valid) begin
      m_busy = 1'b1;
      m_k    = 1;
      m_byte = tx_data;
      m_done = 1'b0;
      acc_cnt++;
    end else if (m_busy) begin
      m_k++;
      m_done = 1'b0;
      if (m_k == F + 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
    #1;
    exp_txd = m_busy ? frame_bit(m_byte, (m_k - 1) / CLK_DIV) : 1'b1;
    chk("txd", 32'(txd), 32'(exp_txd));
    chk("tx_ready", 32'(tx_ready), 32'(!m_busy));
    chk("tx_done", 32'(tx_done), 32'(m_done));
    if (m_busy) cap[m_k] = txd;
    if (!tx_ready) ready_low++;
    if (tx_done) done_cnt++;
    if (prev_ready && !tx_ready) fall_cyc.push_back(cyc);
    prev_ready = tx_ready;
  end

  task automatic send(input logic [7:0] b);
    int  a0;
    bit  ok;
    a0 = acc_cnt;
    ok = 1'b0;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
    tx_valid = 1'b0;
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic check_frame(input string name,
                             input logic [11:0] exp);
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[i] = cap[i*CLK_DIV+2];
    chk(name, 32'(v), 32'(exp));
  endtask

  initial begin
    int a0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    repeat (50) @(negedge clk);

    ready_low = 0;
    done_cnt  = 0;
    send(8'hA5);
    wait_idle();
    chk("a5_done_pulse", 32'(tx_done), 32'd1);
    chk("a5_ready_back", 32'(tx_ready), 32'd1);
    check_frame("a5_frame", E_A5);
    chk("a5_busy_len", 32'(ready_low), 32'(E_F));
    chk("a5_done_cnt", 32'(done_cnt), 32'd1);

    send(8'h07);
    wait_idle();
    check_frame("07_frame", E_07);

    fall_cyc.delete();
    a0 = acc_cnt;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    for (int i = 0; i < 200 && acc_cnt == a0; i++) @(negedge clk);
    tx_data = 8'hFF;
    for (int i = 0; i < 200 && acc_cnt == a0 + 1; i++) @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
    wait_idle();
    check_frame("ff_frame", E_FF);
    chk("b2b_falls", 32'(fall_cyc.size()), 32'd2);
    if (fall_cyc.size() >= 2)
      chk("b2b_gap", 32'(fall_cyc[1] - fall_cyc[0]), 32'(E_F + 1));

    a0 = acc_cnt;
    send(8'h3C);
    @(negedge clk);
    tx_data = 8'hFF;
    repeat (10) @(negedge clk);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();
    check_frame("3c_frame", E_3C);
    chk("3c_one_accept", 32'(acc_cnt - a0), 32'd1);

    done_cnt = 0;
    send(8'h5A);
    repeat (9) @(negedge clk);
    areset = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_mid_txd", 32'(txd), 32'd1);
    chk("rst_mid_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    areset = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    send(8'hC3);
    wait_idle();
    check_frame("c3_frame", E_C3);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(8'($urandom));
      if ($urandom_range(0, 3) == 0) tx_data = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, F)) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
